// File: rtl/c499_lock_pkg.sv
// Shared types and defaults for the c499 key loader.
// Holds the loader FSM encoding and default sizing.
package c499_lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam int DEF_KEY_WIDTH = 2;
    localparam int DEF_TIMEOUT   = 255;

endpackage

// File: rtl/key_shift_reg.sv
// Shadow register for serially delivered key bits.
// Each enabled beat lands at the bit counter's position.
module key_shift_reg
    import c499_lock_pkg::*;
#(
    parameter int W  = DEF_KEY_WIDTH,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          beat_i,
    input  logic          bit_i,
    output logic [W-1:0]  shadow_o,
    output logic [CW-1:0] cnt_o
);

    logic [W-1:0]  shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Indexed write of one key bit; counter stops at W.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            shadow_d = '0;
            cnt_d    = '0;
        end else if (beat_i && (cnt_q < CW'(W))) begin
            for (int i = 0; i < W; i++) begin
                if (cnt_q == CW'(i)) begin
                    shadow_d[i] = bit_i;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Shadow and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign shadow_o = shadow_q;
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/c499_key_loader.sv
// Serial key loader for the key-locked c499 netlist.
// key_out stays zero unless a parity-checked key was loaded.
module c499_key_loader
    import c499_lock_pkg::*;
#(
    parameter int KEY_WIDTH = DEF_KEY_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 key_bit,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_loaded,
    output logic                 key_error
);

    localparam int CW = $clog2(KEY_WIDTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_out_q, key_out_d;
    logic                 loaded_q, loaded_d;
    logic                 error_q, error_d;
    logic                 par_q, par_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    logic                 clr;
    logic                 beat_en;
    logic                 beat;
    logic [KEY_WIDTH-1:0] shadow;
    logic [CW-1:0]        bit_cnt;

    assign key_ready = (state_q == SHIFT);
    assign beat      = key_valid & key_ready;

    key_shift_reg #(
        .W  (KEY_WIDTH),
        .CW (CW)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr),
        .beat_i   (beat_en),
        .bit_i    (key_bit),
        .shadow_o (shadow),
        .cnt_o    (bit_cnt)
    );

    // Next state, parity check, timeout and output updates.
    always_comb begin
        state_d   = state_q;
        key_out_d = key_out_q;
        loaded_d  = loaded_q;
        error_d   = error_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        clr       = 1'b0;
        beat_en   = 1'b0;
        if (load_start) begin
            state_d   = SHIFT;
            key_out_d = '0;
            loaded_d  = 1'b0;
            error_d   = 1'b0;
            par_d     = 1'b0;
            tmo_d     = '0;
            clr       = 1'b1;
        end else begin
            unique case (state_q)
                SHIFT: begin
                    if (beat) begin
                        tmo_d = '0;
                        if (bit_cnt == CW'(KEY_WIDTH)) begin
                            par_d   = key_bit;
                            state_d = CHECK;
                        end else begin
                            beat_en = 1'b1;
                        end
                    end else if (TIMEOUT != 0) begin
                        if (tmo_q == TW'(TIMEOUT - 1)) begin
                            state_d = ERROR;
                            error_d = 1'b1;
                        end else begin
                            tmo_d = tmo_q + TW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (((^shadow) ^ par_q) == 1'b0) begin
                        state_d   = DONE;
                        key_out_d = shadow;
                        loaded_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
                IDLE, DONE, ERROR: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            key_out_q <= '0;
            loaded_q  <= 1'b0;
            error_q   <= 1'b0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_out_q <= key_out_d;
            loaded_q  <= loaded_d;
            error_q   <= error_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    assign key_out    = key_out_q;
    assign key_loaded = loaded_q;
    assign key_error  = error_q;

endmodule
